// File: rtl/dispatch_queue_pkg.sv
// Shared constants for the instruction queue: data widths, load/store opcodes
// and the routing helper that picks the dispatch target.
package dispatch_queue_pkg;

    localparam int INST_WID   = 32;
    localparam int ADDR_WID   = 32;
    localparam int OPCODE_WID = 7;
    localparam int ENTRY_WID  = INST_WID + ADDR_WID + 1;

    localparam logic [OPCODE_WID-1:0] OPCODE_L = 7'b0000011;
    localparam logic [OPCODE_WID-1:0] OPCODE_S = 7'b0100011;

    // Loads and stores go to the LSB; everything else goes to the RS.
    function automatic logic is_lsb_op(input logic [INST_WID-1:0] inst);
        return (inst[OPCODE_WID-1:0] == OPCODE_L) || (inst[OPCODE_WID-1:0] == OPCODE_S);
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Ifetch, decoder and back-end occupancy signals around the dispatch queue.
// The queue takes the slave side; the fetch/decode environment takes the master side.
interface dispatch_queue_if;
    import dispatch_queue_pkg::*;

    logic                if_inst_rdy;
    logic [INST_WID-1:0] if_inst;
    logic [ADDR_WID-1:0] if_inst_pc;
    logic                if_pre_jump;
    logic                iq_full;
    logic                rob_full;
    logic                rs_full;
    logic                lsb_full;
    logic                dec_inst_rdy;
    logic [INST_WID-1:0] dec_inst;
    logic [ADDR_WID-1:0] dec_pc;
    logic                dec_pre_jump;
    logic                iq_ovf;

    modport master (
        output if_inst_rdy, if_inst, if_inst_pc, if_pre_jump,
        output rob_full, rs_full, lsb_full,
        input  iq_full, dec_inst_rdy, dec_inst, dec_pc, dec_pre_jump, iq_ovf
    );

    modport slave (
        input  if_inst_rdy, if_inst, if_inst_pc, if_pre_jump,
        input  rob_full, rs_full, lsb_full,
        output iq_full, dec_inst_rdy, dec_inst, dec_pc, dec_pre_jump, iq_ovf
    );

endinterface

// File: rtl/dispatch_queue_iq_fifo_mem.sv
// Queue entry storage: one synchronous write port and one asynchronous read port.
// No reset; the queue's pointers and count decide which entries are meaningful.
module iq_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int WID   = 65
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WID-1:0]   wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WID-1:0]   rdata
);

    logic [WID-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dispatch_queue.sv
// Instruction queue between ifetch and decode: buffers fetched instructions and
// issues the head once the ROB and its target unit can take it; flushes on rollback.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rollback,
    dispatch_queue_if.slave iq
);

    // state | meaning
    // RUN   | normal push/pop
    // FLUSH | one cycle after rollback; drops stale fetches still in flight
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_HI  = (PTR_W+1)'(DEPTH - 1);

    state_t               state;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       count;
    logic                 ovf;
    logic [ENTRY_WID-1:0] head_entry;
    logic [ENTRY_WID-1:0] wr_entry;
    logic                 run;
    logic                 tgt_full;
    logic                 pop;
    logic                 push;
    logic                 wr_en;

    assign run      = (state == RUN);
    assign tgt_full = is_lsb_op(head_entry[ENTRY_WID-1 -: INST_WID]) ? iq.lsb_full : iq.rs_full;
    assign pop      = rst & rdy & !rollback & run & (count != '0) & !iq.rob_full & !tgt_full;
    assign push     = iq.if_inst_rdy & rdy & !rollback & run;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign wr_en    = push & ((count != CNT_MAX) | pop);
    assign wr_entry = {iq.if_inst, iq.if_inst_pc, iq.if_pre_jump};

    // One entry of slack so ifetch may register iq_full without overrunning.
    assign iq.iq_full      = !rst | (state == FLUSH) | (count >= CNT_HI);
    assign iq.dec_inst_rdy = pop;
    assign iq.dec_inst     = head_entry[ENTRY_WID-1 -: INST_WID];
    assign iq.dec_pc       = head_entry[ADDR_WID:1];
    assign iq.dec_pre_jump = head_entry[0];
    assign iq.iq_ovf       = ovf;

    iq_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WID   (ENTRY_WID)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (head_entry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (rdy) begin
            case (state)
                RUN: begin
                    if (rollback) begin
                        state <= FLUSH;
                        head  <= '0;
                        tail  <= '0;
                        count <= '0;
                    end else begin
                        if (pop)   head <= head + 1'b1;
                        if (wr_en) tail <= tail + 1'b1;
                        if (wr_en && !pop)      count <= count + 1'b1;
                        else if (pop && !wr_en) count <= count - 1'b1;
                        if (push && !wr_en) ovf <= 1'b1;
                    end
                end
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
